// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: reads width-bit words from a FIFO and packs consecutive
// pairs into one 2*width-bit output word with a valid/ready handshake.
// Ports:
//   r_clk      - clock, all state updates on posedge
//   rst        - synchronous active-high reset
//   empty_flag - FIFO empty; blocks new reads only
//   r_data     - FIFO read data, valid the cycle after r_en is sampled high
//   r_en       - FIFO read enable (combinational from registered state)
//   out_data   - packed word {second, first}, registered
//   out_valid  - out_data holds an untransferred word, registered
//   out_ready  - downstream accept
//   pkt_cnt    - count of completed transfers, wraps at 16 bits
module fifo_rd_packer #(
  parameter int unsigned width = 16
) (
  input  logic                 r_clk,
  input  logic                 rst,
  input  logic                 empty_flag,
  input  logic [width-1:0]     r_data,
  output logic                 r_en,
  output logic [2*width-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          pkt_cnt
);

  localparam int unsigned OUT_W = 2 * width;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OCC_W = 3;

  logic                rd_pend_q, rd_pend_d;
  logic [width-1:0]    lo_reg_q, lo_reg_d;
  logic                lo_valid_q, lo_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

  logic [OCC_W-1:0]    words_c;
  logic                xfer_c;

  // Words owned by the packer: a full output counts two, plus held and in-flight.
  // Capping at three keeps a combine from ever landing on a stalled output.
  always_comb begin
    words_c = OCC_W'({out_valid_q, 1'b0}) + OCC_W'(lo_valid_q) + OCC_W'(rd_pend_q);
  end

  assign r_en   = !rst && !empty_flag && (words_c < OCC_W'(3));
  assign xfer_c = out_valid_q && out_ready;

  // Next-state: capture returning word into lo_reg or combine into the output.
  always_comb begin
    rd_pend_d   = r_en;
    lo_reg_d    = lo_reg_q;
    lo_valid_d  = lo_valid_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (xfer_c) begin
      out_valid_d = 1'b0;
      pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
    end

    if (rd_pend_q) begin
      if (lo_valid_q) begin
        out_data_d  = {r_data, lo_reg_q};
        out_valid_d = 1'b1;
        lo_valid_d  = 1'b0;
      end else begin
        lo_reg_d   = r_data;
        lo_valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      lo_reg_q    <= '0;
      lo_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      lo_reg_q    <= lo_reg_d;
      lo_valid_q  <= lo_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model driver, negedge scoreboard monitor,
// and one task per scenario.
module tb_fifo_rd_packer;

  localparam int unsigned W = 16;

  logic           clk;
  logic           rst;
  logic           empty_flag;
  logic [W-1:0]   r_data;
  logic           r_en;
  logic [2*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    pkt_cnt;

  fifo_rd_packer #(.width(W)) dut (
    .r_clk      (clk),
    .rst        (rst),
    .empty_flag (empty_flag),
    .r_data     (r_data),
    .r_en       (r_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pkt_cnt    (pkt_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]   fifo[$];
  logic [W-1:0]   sbq[$];
  logic [2*W-1:0] obs_q[$];

  int   ready_mode = 0;
  bit   stall_en   = 0;
  bit   pop_req    = 0;

  int          n_read = 0;
  int          n_xfer = 0;
  int          n_arr  = 0;
  int          ov_cycles = 0;
  bit          ren_h1 = 0;
  bit          ren_h2 = 0;
  bit          rst_prev = 0;
  logic [15:0] exp_pkt = 16'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // FIFO model: returns data the cycle after a sampled read, drives flags.
  initial begin
    r_data     = '0;
    empty_flag = 1'b1;
    out_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_req && fifo.size() > 0) begin
        r_data = fifo.pop_front();
        sbq.push_back(r_data);
      end else begin
        r_data = W'($urandom);
      end
      empty_flag = (fifo.size() == 0) || (stall_en && $urandom_range(0, 4) == 0);
      case (ready_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Reference model: occupancy = words read minus two per transfer; a word
  // read in cycle c is held by the packer from cycle c+2.
  always @(negedge clk) begin
    int occ;
    int held;
    bit exp_ren;
    bit exp_ov;
    if (rst) begin
      n_tests++;
      if (r_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_ren: r_en=%0b required 0 at %0t", r_en, $time);
      end
      if (rst_prev) begin
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || pkt_cnt !== 16'h0) begin
          n_fail++;
          $display("FAIL rst_out: valid=%0b data=%h cnt=%h required 0 at %0t",
                   out_valid, out_data, pkt_cnt, $time);
        end
      end
      rst_prev = 1;
      sbq.delete();
      n_read = 0; n_xfer = 0; n_arr = 0;
      ren_h1 = 0; ren_h2 = 0;
      exp_pkt = 16'h0;
      pop_req = 0;
    end else begin
      rst_prev = 0;
      n_arr += int'(ren_h2);
      occ  = n_read - 2 * n_xfer;
      held = n_arr - 2 * n_xfer;
      exp_ren = !empty_flag && (occ < 3);
      exp_ov  = (held >= 2);
      n_tests++;
      if (r_en !== exp_ren) begin
        n_fail++;
        $display("FAIL r_en: got %0b required %0b (empty=%0b occ=%0d) at %0t",
                 r_en, exp_ren, empty_flag, occ, $time);
      end
      n_tests++;
      if (out_valid !== exp_ov) begin
        n_fail++;
        $display("FAIL out_valid: got %0b required %0b at %0t", out_valid, exp_ov, $time);
      end
      if (out_valid && sbq.size() >= 2) begin
        n_tests++;
        if (out_data !== {sbq[1], sbq[0]}) begin
          n_fail++;
          $display("FAIL out_data: got %h required %h at %0t", out_data, {sbq[1], sbq[0]}, $time);
        end
      end
      n_tests++;
      if (pkt_cnt !== exp_pkt) begin
        n_fail++;
        $display("FAIL pkt_cnt: got %h required %h at %0t", pkt_cnt, exp_pkt, $time);
      end
      if (out_valid) ov_cycles++;
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        if (sbq.size() >= 2) begin
          void'(sbq.pop_front());
          void'(sbq.pop_front());
        end
        n_xfer++;
        exp_pkt = exp_pkt + 16'h1;
      end
      pop_req = r_en;
      n_read += int'(r_en);
      ren_h2 = ren_h1;
      ren_h1 = r_en;
    end
  end

  task automatic reset_on();
    rst = 1'b1;
    fifo.delete();
    repeat (2) @(negedge clk);
    obs_q.delete();
    ov_cycles = 0;
  endtask

  task automatic reset_off();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (r_en !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || pkt_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL test_reset: en=%0b valid=%0b data=%h cnt=%h required all 0",
               r_en, out_valid, out_data, pkt_cnt);
    end
  endtask

  task automatic test_single_pair();
    reset_on();
    ready_mode = 1;
    stall_en   = 0;
    fifo.push_back(16'h0001);
    fifo.push_back(16'h0002);
    reset_off();
    repeat (12) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h0002_0001) begin
      n_fail++;
      $display("FAIL single_pair_data: got %0d words first %h required 1 word 00020001",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
    end
    n_tests++;
    if (n_read != 2 || ov_cycles != 1 || pkt_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_pair_counts: reads=%0d valid_cycles=%0d cnt=%0d required 2 1 1",
               n_read, ov_cycles, pkt_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] exp_w[4];
    exp_w[0] = 32'h0002_0001; exp_w[1] = 32'h0004_0003;
    exp_w[2] = 32'h0006_0005; exp_w[3] = 32'h0008_0007;
    reset_on();
    ready_mode = 0;
    stall_en   = 0;
    for (int i = 1; i <= 8; i++) fifo.push_back(W'(i));
    reset_off();
    repeat (20) @(negedge clk);
    n_tests++;
    if (n_read != 3 || out_valid !== 1'b1 || out_data !== 32'h0002_0001) begin
      n_fail++;
      $display("FAIL backpressure_hold: reads=%0d valid=%0b data=%h required 3 1 00020001",
               n_read, out_valid, out_data);
    end
    ready_mode = 1;
    repeat (40) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 4 || pkt_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL backpressure_count: words=%0d cnt=%0d required 4 4", obs_q.size(), pkt_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) begin
        n_tests++;
        if (obs_q[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL backpressure_word%0d: got %h required %h", i, obs_q[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_odd_trailing();
    reset_on();
    ready_mode = 1;
    stall_en   = 0;
    fifo.push_back(16'h000A);
    fifo.push_back(16'h000B);
    fifo.push_back(16'h000C);
    reset_off();
    repeat (25) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h000B_000A) begin
      n_fail++;
      $display("FAIL odd_trailing_data: words=%0d first=%h required 1 000b000a",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
    end
    n_tests++;
    if (n_read != 3 || ov_cycles != 1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_trailing_state: reads=%0d valid_cycles=%0d valid=%0b required 3 1 0",
               n_read, ov_cycles, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    reset_on();
    ready_mode = 1;
    stall_en   = 0;
    fifo.push_back(16'h0011);
    fifo.push_back(16'h0012);
    reset_off();
    // Two reads issued; third cycle has one word held and one returning.
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_on();
    n_tests++;
    if (r_en !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || pkt_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_clear: en=%0b valid=%0b data=%h cnt=%h required all 0",
               r_en, out_valid, out_data, pkt_cnt);
    end
    fifo.push_back(16'h0005);
    fifo.push_back(16'h0006);
    reset_off();
    repeat (12) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h0006_0005) begin
      n_fail++;
      $display("FAIL midreset_after: words=%0d first=%h required 1 00060005",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
    end
  endtask

  task automatic test_pkt_wrap();
    reset_on();
    ready_mode = 1;
    stall_en   = 0;
    reset_off();
    @(posedge clk);
    #1;
    force dut.pkt_cnt_q = 16'hFFFE;
    exp_pkt = 16'hFFFE;
    @(negedge clk);
    release dut.pkt_cnt_q;
    for (int i = 0; i < 4; i++) fifo.push_back(W'($urandom));
    repeat (20) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 2 || pkt_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL pkt_wrap: words=%0d cnt=%h required 2 0000", obs_q.size(), pkt_cnt);
    end
  endtask

  task automatic test_random();
    localparam int NWORDS = 10000;
    logic [W-1:0] words[$];
    int bad;
    reset_on();
    ready_mode = 2;
    stall_en   = 1;
    for (int i = 0; i < NWORDS; i++) begin
      words.push_back(W'($urandom));
      fifo.push_back(words[i]);
    end
    reset_off();
    for (int i = 0; i < 60000 && obs_q.size() < NWORDS / 2; i++) @(negedge clk);
    n_tests++;
    if (obs_q.size() != NWORDS / 2 || pkt_cnt !== 16'(NWORDS / 2)) begin
      n_fail++;
      $display("FAIL random_count: words=%0d cnt=%0d required %0d", obs_q.size(), pkt_cnt, NWORDS / 2);
    end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < NWORDS / 2; i++) begin
      if (obs_q[i] !== {words[2 * i + 1], words[2 * i]}) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_order: %0d out-of-order or corrupt pairs, required 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_pair();
    test_backpressure();
    test_odd_trailing();
    test_reset_midstream();
    test_pkt_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
